// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB types and helpers for the ahb_slave_mem slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } slv_state_e;

    // Number of byte lanes on a data bus of the given width.
    function automatic int unsigned lane_count(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB bus signals between a single master and the memory slave.
interface ahb_slave_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 2
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic          error;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic [RW-1:0] hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, error,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, error,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_slave_mem_byte_lane_gen.sv
// Byte-enable mask for one transfer from its size and low address bits.
module ahb_byte_lane_gen #(
    parameter int DW = 32
) (
    input  logic [2:0]               hsize,
    input  logic [$clog2(DW/8)-1:0]  addr_lo,
    input  logic                     de,
    output logic [DW/8-1:0]          be
);
    localparam int unsigned NB = DW / 8;

    logic [NB-1:0] be_lin;

    // A lane is enabled when it shares the 2**hsize-aligned block with the address;
    // big-endian mirrors the lanes within the word.
    always_comb begin
        be_lin = '0;
        be     = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if ((i >> hsize) == (32'(addr_lo) >> hsize)) begin
                be_lin[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NB; i++) begin
            be[i] = de ? be_lin[NB-1-i] : be_lin[i];
        end
    end
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave with on-chip word memory, programmable wait states and ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DE          = 0,
    parameter int RW          = 2,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            hclk,
    input  logic            hresetn,
    ahb_slave_mem_if.slave  bus
);
    localparam int unsigned NB   = lane_count(DW);
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slv_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            hready_q, hready_d;
    logic [RW-1:0]   hresp_q, hresp_d;
    logic            write_q, write_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [OFFW-1:0] addr_lo_q, addr_lo_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [NB-1:0]   be;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   word_addr;
    logic [AW-1:0]   size_mask;
    logic            valid;
    logic            err_cond;
    logic            unused_ok;

    // Address-phase decode: transfer validity and error condition.
    always_comb begin
        valid     = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
        word_addr = bus.haddr >> OFFW;
        size_mask = (AW'(1) << bus.hsize) - AW'(1);
        err_cond  = bus.error
                 || (word_addr >= AW'(DEPTH))
                 || (bus.hsize > 3'(OFFW))
                 || ((bus.haddr & size_mask) != '0);
    end

    // Next state, wait counter, captured address phase and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        hsize_d   = hsize_q;
        addr_lo_d = addr_lo_q;
        idx_d     = idx_q;
        if (state_q == IDLE || state_q == DATA || state_q == ERR2) begin
            write_d   = bus.hwrite;
            hsize_d   = bus.hsize;
            addr_lo_d = bus.haddr[OFFW-1:0];
            idx_d     = word_addr[IW-1:0];
            if (valid && err_cond) begin
                state_d = ERR1;
            end else if (valid) begin
                if (WAIT_STATES == 0) begin
                    state_d = DATA;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == WAIT) begin
            if (cnt_q == '0) begin
                state_d = DATA;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            state_d = ERR2;
        end
        hready_d = (state_d == IDLE) || (state_d == DATA) || (state_d == ERR2);
        hresp_d  = ((state_d == ERR1) || (state_d == ERR2)) ? RW'(HRESP_ERROR) : RW'(HRESP_OKAY);
    end

    // State and address-phase registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= RW'(HRESP_OKAY);
            write_q   <= 1'b0;
            hsize_q   <= '0;
            addr_lo_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            write_q   <= write_d;
            hsize_q   <= hsize_d;
            addr_lo_q <= addr_lo_d;
            idx_q     <= idx_d;
        end
    end

    ahb_byte_lane_gen #(.DW(DW)) u_lane (
        .hsize   (hsize_q),
        .addr_lo (addr_lo_q),
        .de      (DE != 0),
        .be      (be)
    );

    // Byte-lane write at the completing edge of a write data phase.
    always_ff @(posedge hclk) begin
        if (state_q == DATA && write_q) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx_q][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data is combinational from the array so a write committed at the
    // edge opening a back-to-back read is already visible.
    assign bus.hrdata = (state_q == DATA) ? mem[idx_q] : '0;
    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;
    assign unused_ok  = ^{bus.hburst, bus.hprot};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem across three configurations.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic hclk    = 1'b0;
    logic hresetn = 1'b1;
    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic [31:0] haddr_d  = '0;
    logic [31:0] hwdata_d = '0;
    logic [1:0]  htrans_d = HTRANS_IDLE;
    logic        hwrite_d = 1'b0;
    logic [2:0]  hsize_d  = HSIZE_WORD;
    logic        err_d    = 1'b0;

    ahb_slave_mem_if #(.AW(32), .DW(32), .RW(2)) if0 ();
    ahb_slave_mem_if #(.AW(32), .DW(32), .RW(2)) if1 ();
    ahb_slave_mem_if #(.AW(32), .DW(32), .RW(2)) if2 ();

`define DRV(IFN, IDX) \
    assign IFN.htrans = (sel == IDX) ? htrans_d : 2'b00; \
    assign IFN.haddr  = haddr_d; \
    assign IFN.hwrite = hwrite_d; \
    assign IFN.hsize  = hsize_d; \
    assign IFN.hburst = 3'b000; \
    assign IFN.hprot  = 4'b0011; \
    assign IFN.hwdata = hwdata_d; \
    assign IFN.error  = err_d;

    `DRV(if0, 0)
    `DRV(if1, 1)
    `DRV(if2, 2)

    ahb_slave_mem #(.AW(32), .DW(32), .DE(0), .RW(2), .DEPTH(256), .WAIT_STATES(0))
        u_dut0 (.hclk(hclk), .hresetn(hresetn), .bus(if0.slave));
    ahb_slave_mem #(.AW(32), .DW(32), .DE(1), .RW(2), .DEPTH(256), .WAIT_STATES(2))
        u_dut1 (.hclk(hclk), .hresetn(hresetn), .bus(if1.slave));
    ahb_slave_mem #(.AW(32), .DW(32), .DE(0), .RW(2), .DEPTH(256), .WAIT_STATES(3))
        u_dut2 (.hclk(hclk), .hresetn(hresetn), .bus(if2.slave));

    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;

    always_comb begin
        case (sel)
            0:       begin rdy = if0.hready; resp = if0.hresp; rdata = if0.hrdata; end
            1:       begin rdy = if1.hready; resp = if1.hresp; rdata = if1.hrdata; end
            default: begin rdy = if2.hready; resp = if2.hresp; rdata = if2.hrdata; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; entered and left at posedge+1.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic e, input logic [1:0] tr,
                        input int exp_waits, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd, input string tag);
        int waits;
        htrans_d = tr;
        haddr_d  = a;
        hwrite_d = w;
        hsize_d  = sz;
        err_d    = e;
        @(posedge hclk); #1;
        htrans_d = HTRANS_IDLE;
        hwdata_d = wd;
        err_d    = 1'b0;
        if (exp_err) begin
            chk({tag, "/err1_ready"}, 32'(rdy), 32'd0);
            chk({tag, "/err1_resp"}, 32'(resp), 32'd1);
            @(posedge hclk); #1;
            chk({tag, "/err2_ready"}, 32'(rdy), 32'd1);
            chk({tag, "/err2_resp"}, 32'(resp), 32'd1);
            chk({tag, "/err2_rdata"}, rdata, 32'd0);
            @(posedge hclk); #1;
        end else begin
            waits = 0;
            while (rdy !== 1'b1 && waits < 40) begin
                chk({tag, "/wait_resp"}, 32'(resp), 32'd0);
                @(posedge hclk); #1;
                waits++;
            end
            chk({tag, "/waits"}, 32'(waits), 32'(exp_waits));
            chk({tag, "/ready"}, 32'(rdy), 32'd1);
            chk({tag, "/resp"}, 32'(resp), 32'd0);
            if (chk_rd) chk({tag, "/rdata"}, rdata, exp_rd);
            @(posedge hclk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state on all three instances.
        #2 hresetn = 1'b0;
        #6;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #0;
            chk("reset_ready", 32'(rdy), 32'd1);
            chk("reset_resp", 32'(resp), 32'd0);
            chk("reset_rdata", rdata, 32'd0);
        end
        sel = 0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Zero-wait write then read.
        sel = 0;
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b0, '0, "t1_wr");
        xfer(1'b0, 32'h10, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'hDEADBEEF, "t1_rd");

        // Back-to-back write then read of the same word.
        htrans_d = HTRANS_NONSEQ; haddr_d = 32'h14; hwrite_d = 1'b1; hsize_d = HSIZE_WORD;
        @(posedge hclk); #1;
        chk("raw_wr_ready", 32'(rdy), 32'd1);
        hwdata_d = 32'hCAFEF00D; hwrite_d = 1'b0;
        @(posedge hclk); #1;
        htrans_d = HTRANS_IDLE;
        chk("raw_rd_ready", 32'(rdy), 32'd1);
        chk("raw_rd_rdata", rdata, 32'hCAFEF00D);
        @(posedge hclk); #1;

        // Two wait states.
        sel = 1;
        xfer(1'b1, 32'h20, HSIZE_WORD, 32'h12345678, 1'b0, HTRANS_NONSEQ, 2, 1'b0, 1'b0, '0, "t2_wr");
        xfer(1'b0, 32'h20, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 2, 1'b0, 1'b1, 32'h12345678, "t2_rd");

        // Byte write, little-endian then big-endian lanes.
        sel = 0;
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11223344, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b0, '0, "t3le_wr");
        xfer(1'b1, 32'h13, HSIZE_BYTE, 32'hAB000000, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b0, '0, "t3le_wb");
        xfer(1'b0, 32'h10, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'hAB223344, "t3le_rd");
        sel = 1;
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11223344, 1'b0, HTRANS_NONSEQ, 2, 1'b0, 1'b0, '0, "t3be_wr");
        xfer(1'b1, 32'h13, HSIZE_BYTE, 32'h000000AB, 1'b0, HTRANS_NONSEQ, 2, 1'b0, 1'b0, '0, "t3be_wb");
        xfer(1'b0, 32'h10, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 2, 1'b0, 1'b1, 32'h112233AB, "t3be_rd");

        // Out-of-range address errors; aliased word and top word untouched.
        sel = 0;
        xfer(1'b1, 32'h000, HSIZE_WORD, 32'h77777777, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b0, '0, "t4_init");
        xfer(1'b1, 32'h3FC, HSIZE_WORD, 32'h5A5AA5A5, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b0, '0, "t4_top_wr");
        xfer(1'b1, 32'h400, HSIZE_WORD, 32'h99999999, 1'b0, HTRANS_NONSEQ, 0, 1'b1, 1'b0, '0, "t4_oor");
        xfer(1'b0, 32'h000, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'h77777777, "t4_alias_rd");
        xfer(1'b0, 32'h3FC, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'h5A5AA5A5, "t4_top_rd");

        // Misaligned, oversize and forced errors; IDLE/BUSY are zero-wait OKAY.
        xfer(1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, 1'b0, HTRANS_NONSEQ, 0, 1'b1, 1'b0, '0, "t5_misalign");
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'h00000000, 1'b1, HTRANS_NONSEQ, 0, 1'b1, 1'b0, '0, "t5_forced");
        xfer(1'b1, 32'h10, HSIZE_DWORD, 32'h00000000, 1'b0, HTRANS_NONSEQ, 0, 1'b1, 1'b0, '0, "t5_oversize");
        xfer(1'b0, 32'h10, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'hAB223344, "t5_rd");
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'h0, 1'b0, HTRANS_IDLE, 0, 1'b0, 1'b0, '0, "t5_idle");
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'h0, 1'b0, HTRANS_BUSY, 0, 1'b0, 1'b0, '0, "t5_busy");
        xfer(1'b0, 32'h10, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 0, 1'b0, 1'b1, 32'hAB223344, "t5_rd2");
        sel = 1;
        xfer(1'b0, 32'h20, HSIZE_WORD, '0, 1'b0, HTRANS_IDLE, 0, 1'b0, 1'b0, '0, "t5_idle_ws");
        xfer(1'b0, 32'h20, HSIZE_WORD, '0, 1'b0, HTRANS_SEQ, 2, 1'b0, 1'b1, 32'h12345678, "t5_seq_rd");

        // Reset in the middle of a wait sequence drops the write.
        sel = 2;
        xfer(1'b1, 32'h30, HSIZE_WORD, 32'h55555555, 1'b0, HTRANS_NONSEQ, 3, 1'b0, 1'b0, '0, "t6_init");
        htrans_d = HTRANS_NONSEQ; haddr_d = 32'h30; hwrite_d = 1'b1; hsize_d = HSIZE_WORD;
        @(posedge hclk); #1;
        htrans_d = HTRANS_IDLE; hwdata_d = 32'hAAAAAAAA;
        chk("t6_wait1_ready", 32'(rdy), 32'd0);
        @(posedge hclk); #1;
        chk("t6_wait2_ready", 32'(rdy), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(rdy), 32'd1);
        chk("t6_rst_resp", 32'(resp), 32'd0);
        chk("t6_rst_rdata", rdata, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(1'b0, 32'h30, HSIZE_WORD, '0, 1'b0, HTRANS_NONSEQ, 3, 1'b0, 1'b1, 32'h55555555, "t6_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AMBA AHB slave (responder) with on-chip word memory. It is the counterpart of the AHB master driver and serves as the DUT-side target for the AHB test environment. It decodes address/data pipelined transfers, inserts a configurable number of wait states, applies byte-lane writes, returns read data, and issues the two-cycle ERROR response on illegal or externally forced errors. It is a single-slave system, so no hsel decode is performed.

Parameters:
AW, 32, address bus width
DW, 32, data bus width (32 or 64)
DE, 0, endianess: 0 little-endian, 1 big-endian (byte lanes mirrored within the word)
RW, 2, hresp width (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT; only OKAY and ERROR are generated)
DEPTH, 256, memory size in DW-bit words
WAIT_STATES, 0, hready-low cycles inserted per OKAY transfer (0..15)

Ports:
hclk  input  1  clock
hresetn  input  1  asynchronous active-low reset
haddr  input  AW  address
htrans  input  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
hwrite  input  1  1 = write
hsize  input  3  transfer size, log2 of bytes
hburst  input  3  burst type; no functional effect
hprot  input  4  protection; no functional effect
hwdata  input  DW  write data, valid in data phase
error  input  1  external error request, sampled with the address phase
hrdata  output  DW  read data
hready  output  1  transfer done / slave ready
hresp  output  RW  transfer response

Behaviour:
- Reset (asynchronous, any state): state IDLE, hready=1, hresp=00, hrdata=0, wait counter=0, captured address-phase registers=0. Memory is not reset. An in-flight write is dropped.
- Address phase is sampled at a posedge where hready=1 (states IDLE, DATA, ERR2).
- A transfer is valid when htrans is NONSEQ or SEQ. IDLE and BUSY transfers get zero-wait OKAY and nothing is accessed.
- Error condition, evaluated at address phase:
  - error=1, or
  - word index haddr/(DW/8) >= DEPTH, or
  - 2**hsize > DW/8, or
  - haddr not aligned to 2**hsize.
- States:
  - IDLE: hready=1, hresp=OKAY.
  - WAIT: hready=0, hresp=OKAY.
  - DATA: completion cycle; hready=1, hresp=OKAY.
  - ERR1: hready=0, hresp=ERROR.
  - ERR2: hready=1, hresp=ERROR.
- Transitions from IDLE/DATA/ERR2 (address sampled):
  - valid and error condition -> ERR1.
  - valid, WAIT_STATES=0 -> DATA.
  - valid, WAIT_STATES>0 -> WAIT with cnt=WAIT_STATES-1.
  - otherwise -> IDLE.
- WAIT: cnt==0 -> DATA, else cnt-1. ERR1 -> ERR2 unconditionally.
- OKAY latency: WAIT_STATES+1 cycles from the address-phase edge to the completing edge.
- Write: in DATA, enabled bytes of hwdata are stored at the completing edge. Byte enables are derived from the captured hsize and haddr low bits, lane-mirrored when DE=1. Disabled bytes are unchanged.
- Read: in DATA, hrdata = full memory word at the captured address; in all other states hrdata=0. The master extracts the lanes.
- Read-after-write to the same address in back-to-back transfers returns the new data, because the write commits at the edge that starts the read's data phase.
- ERR path: memory is never written and hrdata=0.
- A transfer sampled in ERR2 is accepted normally. Masters are expected to present IDLE there.

Decomposition:
- Package ahb_pkg holds:
  - htrans_e, hresp_e, and hsize constants;
  - slv_state_e {IDLE, WAIT, DATA, ERR1, ERR2};
  - byte-lane count function.
- Sub-module ahb_byte_lane_gen: combinational; inputs hsize, haddr low bits, DE; output byte-enable mask of DW/8 bits.
- The memory array, FSM and address-phase registers live in ahb_slave_mem.

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then word read of 0x10 -> hready stays 1, hresp=00, hrdata=0xDEADBEEF in the read data phase.
2. WAIT_STATES=2: word write 0x12345678 to 0x20 -> hready=0 for exactly 2 cycles, then 1 with OKAY; readback gives 0x12345678 after 2 more wait cycles.
3. Word 0x11223344 at 0x10, then byte write 0xAB to 0x13 (hsize=0), DE=0 -> readback 0xAB223344; same sequence with DE=1 -> 0x112233AB.
4. Word write to 0x400 with DEPTH=256 -> ERR1 (hready=0, hresp=01) then ERR2 (hready=1, hresp=01); a later read of the aliased location 0x000 is unchanged.
5. Halfword write to 0x01 -> two-cycle ERROR. Valid write with error=1 -> two-cycle ERROR with no write. IDLE and BUSY transfers -> OKAY with zero waits.
6. WAIT_STATES=3: write in progress, assert hresetn=0 mid-WAIT -> hready=1, hresp=00, hrdata=0 immediately; readback after reset shows the old memory value.
